// File: rtl/fpm_pkg.sv
// Shared definitions for the FPM mantissa-multiplier sequencer.
// Contents: controller state type, default mantissa width, legal range of
// registered reduction levels and the reduction-counter width.
package fpm_pkg;

    localparam int unsigned MANT_W_DEF     = 24;
    localparam int unsigned RED_CYCLES_MIN = 1;
    localparam int unsigned RED_CYCLES_MAX = 4;
    localparam int unsigned RED_CNT_W      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HARD,
        ST_PPGEN,
        ST_RED,
        ST_CPA,
        ST_DONE
    } fpm_ctrl_state_t;

endpackage

// File: rtl/fpm_mul_ctrl_if.sv
// Operand/result handshake bundle between the multiplier sequencer and its
// producer/consumer.
//   in_valid/in_ready/a_mant/b_mant : operand pair handshake
//   out_valid/out_ready/zero_res    : result handshake and zero-bypass flag
// master = producer/consumer side, slave = sequencer side.
interface fpm_mul_ctrl_if
    import fpm_pkg::*;
#(
    parameter int unsigned MANT_W = MANT_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] a_mant;
    logic [MANT_W-1:0] b_mant;
    logic              out_valid;
    logic              out_ready;
    logic              zero_res;

    modport master (
        output in_valid,
        output a_mant,
        output b_mant,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  zero_res
    );

    modport slave (
        input  in_valid,
        input  a_mant,
        input  b_mant,
        input  out_ready,
        output in_ready,
        output out_valid,
        output zero_res
    );

endinterface

// File: rtl/fpm_flex_cnt.sv
// Clearable, enabled rollover counter. Counts up while count_en_i is high and
// wraps to zero after reaching rollover_val_i. clear_i has priority.
//   clk, n_rst       : clock, asynchronous active-low reset
//   clear_i          : synchronous clear
//   count_en_i       : advance the count
//   rollover_val_i   : terminal count value
//   count_o          : current count
//   rollover_flag_o  : count is at the terminal value
module fpm_flex_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear_i,
    input  logic             count_en_i,
    input  logic [CNT_W-1:0] rollover_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             rollover_flag_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i) begin
            if (count_q == rollover_val_i) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o         = count_q;
    assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/fpm_mul_ctrl.sv
// Sequencer for the radix-8 Booth mantissa multiplier. Latches one operand
// pair per valid/ready accept, then steps the shared datapath through
// HARD (3X multiple) -> PPGEN (PP gen + first reduction) -> RED (remaining
// reduction levels) -> CPA -> DONE. Zero operands jump straight to DONE.
//   clk, n_rst         : clock, asynchronous active-low reset
//   bus (slave)        : operand / result handshake
//   flush              : synchronous abort, highest priority
//   op_a, op_b         : latched operands for the datapath
//   en_3x/en_pp/en_red/en_cpa : per-phase datapath enables
//   red_stage          : active reduction level while in RED
//   busy               : controller not idle
//   op_count           : completed-result counter (wraps)
module fpm_mul_ctrl
    import fpm_pkg::*;
#(
    parameter int unsigned RED_CYCLES = 2,
    parameter int unsigned MANT_W     = MANT_W_DEF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    fpm_mul_ctrl_if.slave        bus,
    input  logic                 flush,
    output logic [MANT_W-1:0]    op_a,
    output logic [MANT_W-1:0]    op_b,
    output logic                 en_3x,
    output logic                 en_pp,
    output logic                 en_red,
    output logic [RED_CNT_W-1:0] red_stage,
    output logic                 en_cpa,
    output logic                 busy,
    output logic [15:0]          op_count
);

    // Out-of-range overrides are pinned to the nearest legal level count.
    localparam int unsigned RED_EFF =
        (RED_CYCLES < RED_CYCLES_MIN) ? RED_CYCLES_MIN :
        (RED_CYCLES > RED_CYCLES_MAX) ? RED_CYCLES_MAX : RED_CYCLES;
    localparam logic [RED_CNT_W-1:0] RED_LAST = RED_CNT_W'(RED_EFF - 1);

    fpm_ctrl_state_t      state_q, state_d;
    logic [MANT_W-1:0]    op_a_q, op_a_d;
    logic [MANT_W-1:0]    op_b_q, op_b_d;
    logic                 zero_q, zero_d;
    logic [15:0]          op_count_q, op_count_d;

    logic                 in_ready;
    logic                 accept;
    logic                 operand_zero;
    logic                 done_hs;
    logic [RED_CNT_W-1:0] red_cnt;
    logic                 red_last;

    fpm_flex_cnt #(
        .CNT_W (RED_CNT_W)
    ) u_red_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (flush),
        .count_en_i      (state_q == ST_RED),
        .rollover_val_i  (RED_LAST),
        .count_o         (red_cnt),
        .rollover_flag_o (red_last)
    );

    // Handshake terms; in_ready is the only output combinational from inputs.
    always_comb begin
        in_ready     = !flush && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_DONE) && bus.out_ready));
        accept       = bus.in_valid && in_ready;
        operand_zero = (bus.a_mant == '0) || (bus.b_mant == '0);
        done_hs      = (state_q == ST_DONE) && bus.out_ready && !flush;
    end

    // Next state and register loads.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        zero_d     = zero_q;
        op_count_d = op_count_q;

        if (accept) begin
            op_a_d = bus.a_mant;
            op_b_d = bus.b_mant;
            zero_d = operand_zero;
        end

        if (done_hs) begin
            op_count_d = op_count_q + 16'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = operand_zero ? ST_DONE : ST_HARD;
                end
            end
            ST_HARD:  state_d = ST_PPGEN;
            ST_PPGEN: state_d = ST_RED;
            ST_RED: begin
                if (red_last) begin
                    state_d = ST_CPA;
                end
            end
            ST_CPA:   state_d = ST_DONE;
            ST_DONE: begin
                // Consumed result with a new accept restarts without an IDLE gap.
                if (bus.out_ready) begin
                    if (accept) begin
                        state_d = operand_zero ? ST_DONE : ST_HARD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            zero_q     <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            zero_q     <= zero_d;
            op_count_q <= op_count_d;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        en_3x         = 1'b0;
        en_pp         = 1'b0;
        en_red        = 1'b0;
        en_cpa        = 1'b0;
        red_stage     = '0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            ST_HARD:  en_3x = 1'b1;
            ST_PPGEN: en_pp = 1'b1;
            ST_RED: begin
                en_red    = 1'b1;
                red_stage = red_cnt;
            end
            ST_CPA:   en_cpa = 1'b1;
            ST_DONE:  bus.out_valid = 1'b1;
            default:  ;
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.zero_res = zero_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign busy         = (state_q != ST_IDLE);
    assign op_count     = op_count_q;

endmodule
